// File: rtl/seq_tx_pkg.sv
// rtl/seq_tx_pkg.sv - shared state encoding, default pattern and width helper for moore_seq_tx (optional GAP state: SEQ_TX_GAP_EN)
package seq_tx_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT,
      S_GAP   = ST_GAP,
      S_DONE  = ST_DONE
   } seq_state_t;

   localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// rtl/seq_shift_reg.sv - parallel-load, shift-left register feeding the serial line MSB-first
module seq_shift_reg #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_load,
   input  logic         i_shift,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_q
);

   // Load wins over shift; zeros enter from the LSB side.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         o_q <= '0;
      end else if (i_load) begin
         o_q <= i_data;
      end else if (i_shift) begin
         o_q <= {o_q[W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/moore_seq_tx.sv
// rtl/moore_seq_tx.sv - Moore serial pattern transmitter (optional inter-repetition gap: SEQ_TX_GAP_EN)
module moore_seq_tx
   import seq_tx_pkg::*;
#(
   parameter int PAT_W      = 4,
   parameter int CNT_W      = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [PAT_W-1:0] i_pattern,
   input  logic [CNT_W-1:0] i_repeat,
   output logic             o_x,
   output logic             o_valid,
   output logic             o_busy,
   output logic             o_done
);

   localparam int               BW       = cnt_width(PAT_W);
   localparam logic [BW-1:0]    BIT_LAST = BW'(PAT_W - 1);

   if (PAT_W < 2 || GAP_CYCLES < 1) begin : g_bad_param
      $error("moore_seq_tx: PAT_W must be >= 2 and GAP_CYCLES >= 1");
   end

   seq_state_t       state;
   logic [PAT_W-1:0] pat_q;
   logic [CNT_W-1:0] rcnt;
   logic [BW-1:0]    bcnt;
   logic [PAT_W-1:0] sh_q;
   logic [PAT_W-1:0] sh_next;
   logic [PAT_W-1:0] load_val;
   logic             sh_load;
   logic             sh_shift;
   logic [CNT_W-1:0] rep_eff;

`ifdef SEQ_TX_GAP_EN
   localparam int               GW       = cnt_width(GAP_CYCLES);
   localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYCLES - 1);
   logic [GW-1:0]    gcnt;
`endif

   assign rep_eff = (i_repeat == '0) ? CNT_W'(1) : i_repeat;

   seq_shift_reg #(.W(PAT_W)) u_shreg (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (sh_load),
      .i_shift (sh_shift),
      .i_data  (load_val),
      .o_q     (sh_q)
   );

   // Shift-register controls, plus its next value so the serial bit can be registered alongside it.
   always_comb begin
      sh_load  = 1'b0;
      sh_shift = 1'b0;
      load_val = pat_q;
      case (state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               sh_load  = 1'b1;
               load_val = i_pattern;
            end
         end
         S_SHIFT: begin
            if (!i_abort) begin
               if (bcnt == BIT_LAST) begin
                  sh_load = (rcnt != CNT_W'(1));
               end else begin
                  sh_shift = 1'b1;
               end
            end
         end
         default: ;
      endcase
      sh_next = sh_load ? load_val : (sh_shift ? {sh_q[PAT_W-2:0], 1'b0} : sh_q);
   end

   // FSM, counters and registered Moore outputs (outputs follow the state being entered).
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state   <= S_IDLE;
         pat_q   <= '0;
         rcnt    <= '0;
         bcnt    <= '0;
`ifdef SEQ_TX_GAP_EN
         gcnt    <= '0;
`endif
         o_x     <= 1'b0;
         o_valid <= 1'b0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         o_x     <= 1'b0;
         o_valid <= 1'b0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  pat_q   <= i_pattern;
                  rcnt    <= rep_eff;
                  bcnt    <= '0;
                  state   <= S_SHIFT;
                  o_x     <= sh_next[PAT_W-1];
                  o_valid <= 1'b1;
                  o_busy  <= 1'b1;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_SHIFT: begin
               if (i_abort) begin
                  state <= S_IDLE;
               end else if (bcnt == BIT_LAST) begin
                  if (rcnt == CNT_W'(1)) begin
                     state  <= S_DONE;
                     o_done <= 1'b1;
                  end else begin
                     rcnt   <= rcnt - CNT_W'(1);
                     bcnt   <= '0;
                     o_busy <= 1'b1;
`ifdef SEQ_TX_GAP_EN
                     gcnt   <= '0;
                     state  <= S_GAP;
`else
                     state   <= S_SHIFT;
                     o_x     <= sh_next[PAT_W-1];
                     o_valid <= 1'b1;
`endif
                  end
               end else begin
                  bcnt    <= bcnt + BW'(1);
                  o_x     <= sh_next[PAT_W-1];
                  o_valid <= 1'b1;
                  o_busy  <= 1'b1;
               end
            end
`ifdef SEQ_TX_GAP_EN
            S_GAP: begin
               // Pattern was reloaded on entry to GAP, so SHIFT resumes straight from sh_q.
               if (i_abort) begin
                  state <= S_IDLE;
               end else if (gcnt == GAP_LAST) begin
                  state   <= S_SHIFT;
                  o_x     <= sh_q[PAT_W-1];
                  o_valid <= 1'b1;
                  o_busy  <= 1'b1;
               end else begin
                  gcnt   <= gcnt + GW'(1);
                  o_busy <= 1'b1;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_moore_seq_tx.sv
// tb/tb_moore_seq_tx.sv - scoreboard testbench for moore_seq_tx (gap scenario under SEQ_TX_GAP_EN)
module tb_moore_seq_tx;

   localparam int PAT_W = 4;
   localparam int GAP_CYCLES = 2;
`ifdef SEQ_TX_GAP_EN
   localparam int GAP_EXTRA = GAP_CYCLES;
`else
   localparam int GAP_EXTRA = 0;
`endif

   logic       i_clk = 1'b0;
   logic       i_reset = 1'b0;
   logic       i_start = 1'b0;
   logic       i_abort = 1'b0;
   logic [3:0] i_pattern = 4'b0000;
   logic [7:0] i_repeat = 8'd0;
   logic       o_x, o_valid, o_busy, o_done;

   int checks = 0;
   int failures = 0;
   logic exp_q[$];
   logic rx[$];

   moore_seq_tx #(.PAT_W(PAT_W), .CNT_W(8), .GAP_CYCLES(GAP_CYCLES)) dut (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_start   (i_start),
      .i_abort   (i_abort),
      .i_pattern (i_pattern),
      .i_repeat  (i_repeat),
      .o_x       (o_x),
      .o_valid   (o_valid),
      .o_busy    (o_busy),
      .o_done    (o_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   // Push the expected serial bits and pulse start for one edge.
   task automatic start_tx(input logic [3:0] pat, input logic [7:0] rep);
      int n;
      n = (rep == 0) ? 1 : int'(rep);
      for (int r = 0; r < n; r++)
         for (int b = 3; b >= 0; b--) exp_q.push_back(pat[b]);
      i_pattern = pat;
      i_repeat  = rep;
      i_start   = 1'b1;
      tick();
      i_start   = 1'b0;
   endtask

   // Scoreboard monitor: pop and compare every valid bit until the done cycle.
   task automatic monitor(input string name, output int cyc, output int nbusy, output bit done);
      logic e;
      cyc = 0; nbusy = 0; done = 0;
      rx.delete();
      for (int i = 0; i < 200; i++) begin
         if (o_done === 1'b1) begin
            done = 1;
            break;
         end
         if (o_valid === 1'b1) begin
            rx.push_back(o_x);
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL %s extra_bit got=%b expected=none", name, o_x);
            end else begin
               e = exp_q.pop_front();
               if (o_x !== e) begin
                  failures++;
                  $display("FAIL %s bit%0d got=%b expected=%b", name, rx.size() - 1, o_x, e);
               end
            end
         end
         if (o_busy === 1'b1) nbusy++;
         cyc++;
         tick();
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL %s done_timeout got=0 expected=1", name);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s missing_bits got=%0d expected=0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   function automatic int count_1011();
      logic [3:0] w = 4'b0000;
      int n = 0;
      int k = 0;
      foreach (rx[i]) begin
         w = {w[2:0], rx[i]};
         k++;
         if (k >= 4 && w == 4'b1011) n++;
      end
      return n;
   endfunction

   task automatic test_reset;
      i_reset = 1'b0; i_start = 1'b1; i_pattern = 4'b1011; i_repeat = 8'd1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({o_x, o_valid, o_busy, o_done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b expected=0000", {o_x, o_valid, o_busy, o_done});
         end
      end
      i_start = 1'b0;
      i_reset = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if ({o_x, o_valid, o_busy, o_done} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_idle_after got=%b expected=0000", {o_x, o_valid, o_busy, o_done});
      end
   endtask

   task automatic test_single;
      int cyc, nb; bit d;
      start_tx(4'b1011, 8'd1);
      monitor("single", cyc, nb, d);
      checks++;
      if (cyc != 4 || nb != 4) begin
         failures++;
         $display("FAIL single_len got=%0d/%0d expected=4/4", cyc, nb);
      end
      tick();
      checks++;
      if ({o_busy, o_done} !== 2'b00) begin
         failures++;
         $display("FAIL single_done_pulse got=%b expected=00", {o_busy, o_done});
      end
   endtask

   task automatic test_overlap;
      int cyc, nb; bit d;
      start_tx(4'b1011, 8'd3);
      i_pattern = 4'b0100;
      i_repeat  = 8'd9;
      monitor("overlap", cyc, nb, d);
      checks++;
      if (cyc != 12 + 2 * GAP_EXTRA || rx.size() != 12) begin
         failures++;
         $display("FAIL overlap_len got=%0d/%0d expected=%0d/12", cyc, rx.size(), 12 + 2 * GAP_EXTRA);
      end
      checks++;
      if (count_1011() != 3) begin
         failures++;
         $display("FAIL overlap_detect got=%0d expected=3", count_1011());
      end
      tick();
   endtask

   task automatic test_repeat_zero;
      int cyc, nb; bit d;
      start_tx(4'b0110, 8'd0);
      monitor("repeat_zero", cyc, nb, d);
      checks++;
      if (cyc != 4) begin
         failures++;
         $display("FAIL repeat_zero_len got=%0d expected=4", cyc);
      end
      tick();
   endtask

   task automatic test_abort;
      int cyc, nb; bit d;
      logic e;
      start_tx(4'b1101, 8'd2);
      for (int j = 0; j < 6; j++) begin
         for (int w = 0; w < 5 && o_valid !== 1'b1; w++) tick();
         e = exp_q.pop_front();
         checks++;
         if (o_valid !== 1'b1 || o_x !== e) begin
            failures++;
            $display("FAIL abort_bit%0d got=%b%b expected=1%b", j, o_valid, o_x, e);
         end
         if (j < 5) tick();
      end
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      exp_q.delete();
      checks++;
      if ({o_x, o_valid, o_busy, o_done} !== 4'b0000) begin
         failures++;
         $display("FAIL abort_outputs got=%b expected=0000", {o_x, o_valid, o_busy, o_done});
      end
      start_tx(4'b1011, 8'd1);
      checks++;
      if (o_valid !== 1'b1) begin
         failures++;
         $display("FAIL abort_restart got=%b expected=1", o_valid);
      end
      monitor("abort_restart", cyc, nb, d);
      tick();
   endtask

   task automatic test_start_abort;
      int cyc, nb; bit d;
      i_abort = 1'b1;
      start_tx(4'b1001, 8'd1);
      i_abort = 1'b0;
      monitor("start_abort", cyc, nb, d);
      checks++;
      if (cyc != 4) begin
         failures++;
         $display("FAIL start_abort_len got=%0d expected=4", cyc);
      end
      tick();
   endtask

   task automatic test_back_to_back;
      int cyc, nb; bit d;
      start_tx(4'b0110, 8'd1);
      monitor("b2b_first", cyc, nb, d);
      start_tx(4'b1011, 8'd2);
      monitor("b2b_second", cyc, nb, d);
      checks++;
      if (cyc != 8 + GAP_EXTRA || rx.size() != 8) begin
         failures++;
         $display("FAIL b2b_len got=%0d/%0d expected=%0d/8", cyc, rx.size(), 8 + GAP_EXTRA);
      end
      tick();
   endtask

`ifdef SEQ_TX_GAP_EN
   task automatic test_gap;
      int cyc, nb; bit d;
      start_tx(4'b1011, 8'd2);
      monitor("gap", cyc, nb, d);
      checks++;
      if (nb != 10 || rx.size() != 8) begin
         failures++;
         $display("FAIL gap_len got=%0d/%0d expected=10/8", nb, rx.size());
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_overlap();
      test_repeat_zero();
      test_abort();
      test_start_abort();
      test_back_to_back();
`ifdef SEQ_TX_GAP_EN
      test_gap();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
